lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit control. Accepts one decoded memory op from EXU,
// issues it as an aligned 8-byte bus beat, and returns the extended load data
// (or fault) to WBU. Optional misalignment fault: YSYX_23060251_LSU_MISALIGN_CHECK_EN.
module lsu_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  mask_i,
    input  logic        is_load_signed_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_wen_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_rsp_err_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  mask_q;
    logic        wen_q;
    logic        signed_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [2:0]  off;
    logic [5:0]  shamt;
    logic [63:0] rd_shifted;
    logic [63:0] load_val;
    logic        op_single;
    logic        misalign;
    logic        in_req;
    logic        in_resp;

    assign off        = addr_q[2:0];
    assign shamt      = {off, 3'b000};
    assign rd_shifted = mem_rdata_i >> shamt;
    assign op_single  = ren_i ^ wen_i;
    assign in_req     = (state == REQ);
    assign in_resp    = (state == RESP);

`ifdef YSYX_23060251_LSU_MISALIGN_CHECK_EN
    // Address must be a multiple of the access size.
    always_comb begin
        misalign = 1'b0;
        case (mask_i)
            8'h03:   misalign = addr_i[0];
            8'h0F:   misalign = |addr_i[1:0];
            8'hFF:   misalign = |addr_i[2:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Select the addressed lane from the bus beat and extend to 64 bits.
    always_comb begin
        load_val = rd_shifted;
        case (mask_q)
            8'h01: load_val = signed_q ? {{56{rd_shifted[7]}},  rd_shifted[7:0]}
                                       : {56'd0, rd_shifted[7:0]};
            8'h03: load_val = signed_q ? {{48{rd_shifted[15]}}, rd_shifted[15:0]}
                                       : {48'd0, rd_shifted[15:0]};
            8'h0F: load_val = signed_q ? {{32{rd_shifted[31]}}, rd_shifted[31:0]}
                                       : {32'd0, rd_shifted[31:0]};
            default: load_val = rd_shifted;
        endcase
    end

    // Request/response FSM with captured request and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            wen_q    <= 1'b0;
            signed_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q   <= addr_i;
                        wdata_q  <= wdata_i;
                        mask_q   <= mask_i;
                        wen_q    <= wen_i;
                        signed_q <= is_load_signed_i;
                        rdata_q  <= '0;
                        if (op_single && !misalign) begin
                            err_q <= 1'b0;
                            state <= REQ;
                        end else begin
                            // no-op completes cleanly; ren&wen or misaligned faults
                            err_q <= op_single ? 1'b1 : (ren_i & wen_i);
                            state <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) state <= WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        err_q   <= mem_rsp_err_i;
                        rdata_q <= (mem_rsp_err_i || wen_q) ? '0 : load_val;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = (state == IDLE);
    assign mem_req_valid_o = in_req;
    assign mem_wen_o       = in_req & wen_q;
    assign mem_addr_o      = in_req ? {addr_q[63:3], 3'b000} : '0;
    assign mem_wstrb_o     = (in_req && wen_q) ? (mask_q << off) : '0;
    assign mem_wdata_o     = in_req ? (wdata_q << shamt) : '0;
    assign rsp_valid_o     = in_resp;
    assign rdata_o         = in_resp ? rdata_q : '0;
    assign err_o           = in_resp & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (default build, no misalign check).
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, ren, wen, is_signed;
    logic [63:0] addr, wdata;
    logic [7:0]  mask;
    logic        rsp_valid, rsp_ready, err;
    logic [63:0] rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [63:0] mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    lsu_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .ren_i            (ren),
        .wen_i            (wen),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .mask_i           (mask),
        .is_load_signed_i (is_signed),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rdata_o          (rdata),
        .err_o            (err),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_wen_o        (mem_wen),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_wstrb_o      (mem_wstrb),
        .mem_rsp_valid_i  (mem_rsp_valid),
        .mem_rdata_i      (mem_rdata),
        .mem_rsp_err_i    (mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; ren = 0; wen = 0; addr = '0; wdata = '0; mask = '0; is_signed = 0;
        rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, ".mem_addr"}, mem_addr, 64'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 64'd0);
        check({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'd0);
        check({tag, ".rdata"}, rdata, 64'd0);
        check({tag, ".err"}, 64'(err), 64'd0);
    endtask

    task automatic drive_req(input logic r, input logic w, input logic [63:0] a,
                             input logic [63:0] wd, input logic [7:0] m, input logic s);
        ren = r; wen = w; addr = a; wdata = wd; mask = m; is_signed = s;
        req_valid = 1;
        tick();
        req_valid = 0; addr = 64'hFFFF_FFFF_FFFF_FFFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        mask = 8'hFF; ren = 0; wen = 0;
    endtask

    // Full bus transaction with optional request and response backpressure.
    task automatic bus_op(input string tag, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] wd, input logic [7:0] m,
                          input logic s, input int unsigned req_stall, input int unsigned rsp_stall,
                          input logic [63:0] mrd, input logic merr,
                          input logic [63:0] exp_maddr, input logic [63:0] exp_wd,
                          input logic [7:0] exp_strb, input logic [63:0] exp_rd, input logic exp_err);
        drive_req(r, w, a, wd, m, s);
        for (int i = 0; i <= int'(req_stall); i++) begin
            check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd1);
            check({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
            check({tag, ".mem_addr"}, mem_addr, exp_maddr);
            check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
            check({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'(exp_strb));
            check({tag, ".mem_wen"}, 64'(mem_wen), 64'(w));
            if (i == int'(req_stall)) mem_req_ready = 1;
            tick();
            mem_req_ready = 0;
        end
        check({tag, ".wait_no_req"}, 64'(mem_req_valid), 64'd0);
        check({tag, ".wait_no_rsp"}, 64'(rsp_valid), 64'd0);
        mem_rsp_valid = 1; mem_rdata = mrd; mem_rsp_err = merr;
        tick();
        mem_rsp_valid = 0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A; mem_rsp_err = 1;
        for (int i = 0; i <= int'(rsp_stall); i++) begin
            check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, ".rdata"}, rdata, exp_rd);
            check({tag, ".err"}, 64'(err), 64'(exp_err));
            if (i == int'(rsp_stall)) rsp_ready = 1;
            tick();
            rsp_ready = 0;
        end
        mem_rsp_err = 0;
        check({tag, ".done_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".done_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    // Op that completes without touching the bus.
    task automatic direct_op(input string tag, input logic r, input logic w, input logic exp_err);
        drive_req(r, w, 64'h8000_0010, 64'h1234, 8'hFF, 1'b0);
        check({tag, ".no_mem_req"}, 64'(mem_req_valid), 64'd0);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, ".rdata"}, rdata, 64'd0);
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check({tag, ".done"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        check_quiet("rst_during");
        rst = 0;
        tick();
        check_quiet("rst_after");

        // sd, aligned double store
        bus_op("sd", 0, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0,
               64'hDEAD_BEEF_DEAD_BEEF, 0,
               64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0);
        // lb signed / lbu at byte 3
        bus_op("lb", 1, 0, 64'h8000_0003, 64'd0, 8'h01, 1, 0, 0,
               64'h0000_0000_80FF_0000, 0,
               64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 0);
        bus_op("lbu", 1, 0, 64'h8000_0003, 64'd0, 8'h01, 0, 0, 0,
               64'h0000_0000_80FF_0000, 0,
               64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0000_0080, 0);
        // sh at byte 6 with bus backpressure
        bus_op("sh", 0, 1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 8'h03, 0, 3, 0,
               64'd0, 0,
               64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0, 64'd0, 0);
        // lw misaligned at byte 6: only two lanes survive, no extension from bit 31
        bus_op("lw_mis", 1, 0, 64'h8000_0006, 64'd0, 8'h0F, 1, 0, 0,
               64'h8765_4321_1234_5678, 0,
               64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0000_8765, 0);
        // lh signed at byte 2, held 5 cycles in RESP
        bus_op("lh", 1, 0, 64'h0000_0002, 64'd0, 8'h03, 1, 0, 5,
               64'h0000_0000_F00D_0000, 0,
               64'h0000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D, 0);
        // lw signed upper word
        bus_op("lw", 1, 0, 64'h0000_0004, 64'd0, 8'h0F, 1, 0, 0,
               64'h8000_0001_0000_0000, 0,
               64'h0000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_8000_0001, 0);
        // ld passes through unchanged even when signed
        bus_op("ld", 1, 0, 64'h0000_0010, 64'd0, 8'hFF, 1, 0, 0,
               64'hFEDC_BA98_7654_3210, 0,
               64'h0000_0010, 64'd0, 8'h00, 64'hFEDC_BA98_7654_3210, 0);
        // bus error forces rdata to zero
        bus_op("ld_err", 1, 0, 64'h8000_0010, 64'd0, 8'hFF, 0, 0, 0,
               64'h0000_0000_0000_1234, 1,
               64'h8000_0010, 64'd0, 8'h00, 64'd0, 1);

        direct_op("nop", 0, 0, 0);
        direct_op("both", 1, 1, 1);

        // request held during the RESP handshake must not be accepted that cycle
        drive_req(0, 0, 64'd0, 64'd0, 8'h01, 0);
        req_valid = 1; rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("resp_hs.rsp_valid", 64'(rsp_valid), 64'd0);
        check("resp_hs.req_ready", 64'(req_ready), 64'd1);
        req_valid = 0;
        tick();

        // reset while waiting for the bus; the late response must be ignored
        drive_req(1, 0, 64'h8000_0000, 64'd0, 8'hFF, 0);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        check_quiet("rst_wait");
        mem_rsp_valid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rsp_valid = 0;
        check_quiet("late_rsp");
        tick();
        check("late_rsp.idle", 64'(req_ready), 64'd1);

        // reset while holding a response
        direct_op_hold();
        rst = 1;
        tick();
        rst = 0;
        check_quiet("rst_resp");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic direct_op_hold();
        drive_req(1, 1, 64'd0, 64'd0, 8'hFF, 0);
        check("hold.rsp_valid", 64'(rsp_valid), 64'd1);
        check("hold.err", 64'(err), 64'd1);
    endtask

endmodule
